// File: rtl/mod_arith_pkg.sv
// Shared types for the modular arithmetic pipelines: opcode, per-stage payload
// and the internal-width helper.
package mod_arith_pkg;

  // Upper bounds for payload fields; unused high bits are constant and trimmed.
  localparam int MAX_DAT_BITS = 256;
  localparam int MAX_CTL_BITS = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef struct packed {
    logic [MAX_DAT_BITS-1:0] a;
    logic [MAX_DAT_BITS-1:0] b;
    logic [MAX_DAT_BITS-1:0] r0;
    logic [MAX_DAT_BITS-1:0] r1;
    logic                    carry0;
    logic                    carry1;
    op_t                     op;
    logic [MAX_CTL_BITS-1:0] ctl;
    logic                    err;
  } stage_t;

  function automatic int dat_bits(input int bits, input int level);
    return level * ((bits + level - 1) / level);
  endfunction

endpackage

// File: rtl/mod_addsub_limb.sv
// One pipeline stage: limb G of both result candidates, chained from the
// previous stage's registered carries, followed by the stage register.
module mod_addsub_limb
  import mod_arith_pkg::*;
#(
  parameter int                      LIMB  = 8,
  parameter int                      G     = 0,
  parameter logic [MAX_DAT_BITS-1:0] P_EXT = '0
) (
  input  logic   aclk,
  input  logic   areset,
  input  logic   load_en,
  input  logic   in_valid,
  input  stage_t in_beat,
  output logic   out_valid,
  output stage_t out_beat
);

  localparam int              LW     = LIMB + 1;
  localparam logic [LIMB-1:0] P_LIMB = P_EXT[G*LIMB +: LIMB];

  logic [LIMB-1:0] a_limb;
  logic [LIMB-1:0] b_limb;
  logic [LW-1:0]   sum0;
  logic [LW-1:0]   sum1;
  stage_t          beat_next;
  stage_t          beat_reg;
  logic            valid_reg;

  // r1 is derived from this limb of r0, so carry1 chains (r0 -/+ P) while
  // carry0 chains (a +/- b); the top bit of each sum is the carry/borrow out.
  always_comb begin
    a_limb = in_beat.a[G*LIMB +: LIMB];
    b_limb = in_beat.b[G*LIMB +: LIMB];
    if (in_beat.op == OP_ADD) begin
      sum0 = {1'b0, a_limb} + {1'b0, b_limb} + LW'(in_beat.carry0);
      sum1 = {1'b0, sum0[LIMB-1:0]} - {1'b0, P_LIMB} - LW'(in_beat.carry1);
    end else begin
      sum0 = {1'b0, a_limb} - {1'b0, b_limb} - LW'(in_beat.carry0);
      sum1 = {1'b0, sum0[LIMB-1:0]} + {1'b0, P_LIMB} + LW'(in_beat.carry1);
    end
    beat_next                    = in_beat;
    beat_next.r0[G*LIMB +: LIMB] = sum0[LIMB-1:0];
    beat_next.r1[G*LIMB +: LIMB] = sum1[LIMB-1:0];
    beat_next.carry0             = sum0[LIMB];
    beat_next.carry1             = sum1[LIMB];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      valid_reg <= 1'b0;
      beat_reg  <= '0;
    end else if (load_en) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        beat_reg <= beat_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_beat  = beat_reg;

endmodule

// File: rtl/mod_addsub_pipe.sv
// Pipelined (a + b) mod P / (a - b) mod P over two joined AXI-stream operands.
// Define MOD_ADDSUB_RANGE_CHECK_EN to add operand range flagging on m_terr.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter logic [MAX_DAT_BITS-1:0] P            = MAX_DAT_BITS'(100),
  parameter int                      BITS         = $clog2(P),
  parameter int                      C_DATA_WIDTH = 32,
  parameter int                      CTL_BITS     = 8,
  parameter int                      LEVEL        = 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [1:0]                s_tvalid,
  input  logic [2*C_DATA_WIDTH-1:0] s_tdata,
  input  logic                      s_top,
  input  logic [CTL_BITS-1:0]       s_tctl,
  output logic [1:0]                s_tready,
  output logic                      m_tvalid,
  output logic [C_DATA_WIDTH-1:0]   m_tdata,
  output logic [CTL_BITS-1:0]       m_tctl,
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  output logic                      m_terr,
`endif
  input  logic                      m_tready
);

  localparam int DAT_BITS = dat_bits(BITS, LEVEL);
  localparam int LIMB     = DAT_BITS / LEVEL;
  localparam int CMP_W    = (C_DATA_WIDTH > MAX_DAT_BITS) ? C_DATA_WIDTH : MAX_DAT_BITS;

  logic [C_DATA_WIDTH-1:0] a_raw;
  logic [C_DATA_WIDTH-1:0] b_raw;
  stage_t                  first_beat;
  stage_t                  beat_in  [LEVEL];
  stage_t                  beat_out [LEVEL];
  logic [LEVEL-1:0]        in_val;
  logic [LEVEL-1:0]        stage_val;
  logic [LEVEL-1:0]        rdy;
  logic                    accept;

  assign a_raw = s_tdata[C_DATA_WIDTH-1:0];
  assign b_raw = s_tdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH];

  always_comb begin
    first_beat     = '0;
    first_beat.a   = MAX_DAT_BITS'(a_raw[BITS-1:0]);
    first_beat.b   = MAX_DAT_BITS'(b_raw[BITS-1:0]);
    first_beat.op  = op_t'(s_top);
    first_beat.ctl = MAX_CTL_BITS'(s_tctl);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    // Full-width compare also catches nonzero bits above BITS.
    first_beat.err = (CMP_W'(a_raw) >= CMP_W'(P)) | (CMP_W'(b_raw) >= CMP_W'(P));
`else
    first_beat.err = 1'b0;
`endif
  end

  // Stage g may load if it or any later stage is empty, or the sink is ready;
  // this is the unrolled form of rdy[g] = ~val[g] | rdy[g+1].
  genvar gi;
  for (gi = 0; gi < LEVEL; gi++) begin : g_stage
    assign rdy[gi] = m_tready | ~(&stage_val[LEVEL-1:gi]);

    if (gi == 0) begin : g_head
      assign beat_in[gi] = first_beat;
      assign in_val[gi]  = accept;
    end else begin : g_body
      assign beat_in[gi] = beat_out[gi-1];
      assign in_val[gi]  = stage_val[gi-1];
    end

    mod_addsub_limb #(
      .LIMB  (LIMB),
      .G     (gi),
      .P_EXT (P)
    ) u_limb (
      .aclk      (aclk),
      .areset    (areset),
      .load_en   (rdy[gi]),
      .in_valid  (in_val[gi]),
      .in_beat   (beat_in[gi]),
      .out_valid (stage_val[gi]),
      .out_beat  (beat_out[gi])
    );
  end

  assign accept   = rdy[0] & s_tvalid[0] & s_tvalid[1] & ~areset;
  assign s_tready = {2{accept}};

  stage_t              last_beat;
  logic                sel_r1;
  logic [DAT_BITS-1:0] result;
  logic                unused_bits;

  assign last_beat = beat_out[LEVEL-1];
  // add: take a+b-P unless it borrowed past the carry of a+b; sub: fix up with +P on borrow.
  assign sel_r1    = (last_beat.op == OP_ADD) ? (last_beat.carry0 | ~last_beat.carry1)
                                              : last_beat.carry0;
  assign result    = sel_r1 ? last_beat.r1[DAT_BITS-1:0] : last_beat.r0[DAT_BITS-1:0];

  assign m_tvalid  = stage_val[LEVEL-1];
  assign m_tdata   = C_DATA_WIDTH'(result[BITS-1:0]);
  assign m_tctl    = last_beat.ctl[CTL_BITS-1:0];
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  assign m_terr    = last_beat.err;
`endif

  assign unused_bits = ^{last_beat, result, s_tdata};

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: three instances (P=100/LEVEL=1,
// P=100/LEVEL=3, P=2^31-1/LEVEL=4) exercised in one linear sequence.
module tb_mod_addsub_pipe
  import mod_arith_pkg::*;
;
  localparam longint P_SMALL = 100;
  localparam longint P_BIG   = 2147483647;
  localparam int     NB      = 1000;

  logic        clk;
  logic        areset;
  logic [1:0]  s_tvalid [3];
  logic [63:0] s_tdata  [3];
  logic        s_top    [3];
  logic [7:0]  s_tctl   [3];
  logic [1:0]  s_tready [3];
  logic        m_tvalid [3];
  logic [31:0] m_tdata  [3];
  logic [7:0]  m_tctl   [3];
  logic        m_tready [3];
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic        m_terr   [3];
`endif

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mod_addsub_pipe #(
      .P            (gi == 2 ? MAX_DAT_BITS'(P_BIG) : MAX_DAT_BITS'(P_SMALL)),
      .C_DATA_WIDTH (32),
      .CTL_BITS     (8),
      .LEVEL        (gi == 0 ? 1 : (gi == 1 ? 3 : 4))
    ) u_dut (
      .aclk     (clk),
      .areset   (areset),
      .s_tvalid (s_tvalid[gi]),
      .s_tdata  (s_tdata[gi]),
      .s_top    (s_top[gi]),
      .s_tctl   (s_tctl[gi]),
      .s_tready (s_tready[gi]),
      .m_tvalid (m_tvalid[gi]),
      .m_tdata  (m_tdata[gi]),
      .m_tctl   (m_tctl[gi]),
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
      .m_terr   (m_terr[gi]),
`endif
      .m_tready (m_tready[gi])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Present one joined beat at a negedge, confirm it is taken, return at the next negedge.
  task automatic send(input int k, input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [7:0] ctl, input string tag);
    s_tvalid[k] = 2'b11;
    s_tdata[k]  = {b, a};
    s_top[k]    = op;
    s_tctl[k]   = ctl;
    #1 check({tag, "_rdy"}, 64'(s_tready[k]), 64'd3);
    @(negedge clk);
    s_tvalid[k] = 2'b00;
  endtask

  task automatic expect_out(input int k, input string tag, input logic [31:0] d, input logic [7:0] c);
    check({tag, "_vld"}, 64'(m_tvalid[k]), 64'd1);
    check({tag, "_dat"}, 64'(m_tdata[k]), 64'(d));
    check({tag, "_ctl"}, 64'(m_tctl[k]), 64'(c));
    $display("txn %s dut=%0d data=%0d ctl=%02h", tag, k, m_tdata[k], m_tctl[k]);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'(P_BIG - 1);
      default: v = 32'($urandom_range(0, 32'(P_BIG - 1)));
    endcase
    return v;
  endfunction

  initial begin
    int          sent;
    int          got;
    int          cyc;
    logic        pend;
    logic        hold;
    logic [31:0] hold_d;
    logic [31:0] ca;
    logic [31:0] cb;
    logic        cop;
    logic [7:0]  cctl;
    longint      r;
    logic [39:0] e;
    logic [39:0] exp_q [$];

    for (int k = 0; k < 3; k++) begin
      s_tvalid[k] = 2'b00;
      s_tdata[k]  = '0;
      s_top[k]    = 1'b0;
      s_tctl[k]   = '0;
      m_tready[k] = 1'b1;
    end
    areset = 1'b1;

    // Reset: ready held low, outputs cleared.
    repeat (2) @(negedge clk);
    s_tvalid[0] = 2'b11;
    #1 check("rst_rdy", 64'(s_tready[0]), 64'd0);
    s_tvalid[0] = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d_vld", k), 64'(m_tvalid[k]), 64'd0);
      check($sformatf("rst%0d_dat", k), 64'(m_tdata[k]), 64'd0);
      check($sformatf("rst%0d_ctl", k), 64'(m_tctl[k]), 64'd0);
    end
    areset = 1'b0;
    @(negedge clk);

    // LEVEL=1 adds, one cycle latency, back to back.
    check("u1_idle", 64'(m_tvalid[0]), 64'd0);
    send(0, 1'b0, 60, 70, 8'h11, "u1_add_60_70");
    expect_out(0, "u1_add_60_70", 30, 8'h11);
    send(0, 1'b0, 99, 0, 8'h12, "u1_add_99_0");
    expect_out(0, "u1_add_99_0", 99, 8'h12);
    send(0, 1'b0, 50, 50, 8'h13, "u1_add_50_50");
    expect_out(0, "u1_add_50_50", 0, 8'h13);
    send(0, 1'b1, 5, 7, 8'h14, "u1_sub_5_7");
    expect_out(0, "u1_sub_5_7", 98, 8'h14);
    send(0, 1'b1, 0, 0, 8'h15, "u1_sub_0_0");
    expect_out(0, "u1_sub_0_0", 0, 8'h15);
    @(negedge clk);
    check("u1_drain", 64'(m_tvalid[0]), 64'd0);

    // Lone valid channel is never acknowledged.
    s_tdata[0] = {32'd3, 32'd4};
    s_tctl[0]  = 8'h20;
    for (int i = 0; i < 7; i++) begin
      s_tvalid[0] = (i < 5) ? 2'b01 : 2'b10;
      #1 check($sformatf("u1_lone%0d_rdy", i), 64'(s_tready[0]), 64'd0);
      @(negedge clk);
    end
    check("u1_lone_noout", 64'(m_tvalid[0]), 64'd0);
    send(0, 1'b0, 4, 3, 8'h21, "u1_join");
    expect_out(0, "u1_join", 7, 8'h21);
    @(negedge clk);
    check("u1_join_once", 64'(m_tvalid[0]), 64'd0);

    // LEVEL=3 subtracts, three cycle latency.
    send(1, 1'b1, 10, 20, 8'hA1, "u3_sub_10_20");
    check("u3_lat1", 64'(m_tvalid[1]), 64'd0);
    send(1, 1'b1, 20, 10, 8'hA2, "u3_sub_20_10");
    check("u3_lat2", 64'(m_tvalid[1]), 64'd0);
    send(1, 1'b1, 0, 99, 8'hA3, "u3_sub_0_99");
    expect_out(1, "u3_sub_10_20", 90, 8'hA1);
    @(negedge clk);
    expect_out(1, "u3_sub_20_10", 10, 8'hA2);
    @(negedge clk);
    expect_out(1, "u3_sub_0_99", 1, 8'hA3);
    @(negedge clk);
    check("u3_drain", 64'(m_tvalid[1]), 64'd0);

    // Backpressure: bubbles collapse, full pipe blocks, output holds, accept+emit together.
    m_tready[1] = 1'b0;
    send(1, 1'b0, 99, 99, 8'hB1, "u3_bp1");
    send(1, 1'b1, 0, 0, 8'hB2, "u3_bp2");
    send(1, 1'b0, 0, 0, 8'hB3, "u3_bp3");
    s_tvalid[1] = 2'b11;
    s_tdata[1]  = {32'd98, 32'd3};
    s_top[1]    = 1'b1;
    s_tctl[1]   = 8'hB4;
    for (int i = 0; i < 2; i++) begin
      #1 check($sformatf("u3_full%0d_rdy", i), 64'(s_tready[1]), 64'd0);
      expect_out(1, $sformatf("u3_hold%0d", i), 98, 8'hB1);
      @(negedge clk);
    end
    m_tready[1] = 1'b1;
    #1 check("u3_bp4_rdy", 64'(s_tready[1]), 64'd3);
    @(negedge clk);
    s_tvalid[1] = 2'b00;
    expect_out(1, "u3_bp2", 0, 8'hB2);
    @(negedge clk);
    expect_out(1, "u3_bp3", 0, 8'hB3);
    @(negedge clk);
    expect_out(1, "u3_bp4", 5, 8'hB4);
    @(negedge clk);
    check("u3_bp_drain", 64'(m_tvalid[1]), 64'd0);

    // Reset with three beats in flight: nothing survives.
    m_tready[1] = 1'b0;
    send(1, 1'b0, 1, 2, 8'hC1, "u3_rs1");
    send(1, 1'b0, 3, 4, 8'hC2, "u3_rs2");
    send(1, 1'b0, 5, 6, 8'hC3, "u3_rs3");
    check("u3_rs_full", 64'(m_tvalid[1]), 64'd1);
    areset = 1'b1;
    @(negedge clk);
    check("u3_rs_vld", 64'(m_tvalid[1]), 64'd0);
    check("u3_rs_dat", 64'(m_tdata[1]), 64'd0);
    check("u3_rs_ctl", 64'(m_tctl[1]), 64'd0);
    areset      = 1'b0;
    m_tready[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("u3_rs_stale%0d", i), 64'(m_tvalid[1]), 64'd0);
    end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    send(0, 1'b0, 100, 1, 8'h31, "rc_100_1");
    check("rc_100_1_err", 64'(m_terr[0]), 64'd1);
    send(0, 1'b0, 99, 1, 8'h32, "rc_99_1");
    check("rc_99_1_err", 64'(m_terr[0]), 64'd0);
    expect_out(0, "rc_99_1", 0, 8'h32);
    @(negedge clk);
`endif

    // Random stream on P=2^31-1, LEVEL=4 with random sink ready.
    sent = 0;
    got  = 0;
    pend = 1'b0;
    hold = 1'b0;
    hold_d = '0;
    for (cyc = 0; cyc < 20000 && (sent < NB || exp_q.size() != 0); cyc++) begin
      m_tready[2] = ($urandom_range(0, 3) != 0);
      if (!pend && sent < NB && $urandom_range(0, 4) != 0) begin
        ca   = rnd_operand();
        cb   = rnd_operand();
        cop  = 1'($urandom_range(0, 1));
        cctl = 8'($urandom_range(0, 255));
        pend = 1'b1;
      end
      if (pend) begin
        s_tvalid[2] = 2'b11;
        s_tdata[2]  = {cb, ca};
        s_top[2]    = cop;
        s_tctl[2]   = cctl;
      end else begin
        s_tvalid[2] = 2'($urandom_range(0, 2));
        s_tdata[2]  = {$urandom, $urandom};
      end
      #1;
      if (hold) begin
        check("u4_hold_vld", 64'(m_tvalid[2]), 64'd1);
        check("u4_hold_dat", 64'(m_tdata[2]), 64'(hold_d));
      end
      if (m_tvalid[2] && m_tready[2]) begin
        check("u4_extra", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("u4_dat%0d", got), 64'(m_tdata[2]), 64'(e[31:0]));
          check($sformatf("u4_ctl%0d", got), 64'(m_tctl[2]), 64'(e[39:32]));
          $display("txn u4 beat=%0d data=%0d ctl=%02h", got, m_tdata[2], m_tctl[2]);
          got++;
        end
      end
      hold   = m_tvalid[2] && !m_tready[2];
      hold_d = m_tdata[2];
      if (!pend) begin
        check("u4_lone_rdy", 64'(s_tready[2]), 64'd0);
      end else if (s_tready[2] == 2'b11) begin
        if (cop == 1'b0) r = (longint'(ca) + longint'(cb)) % P_BIG;
        else             r = (longint'(ca) + P_BIG - longint'(cb)) % P_BIG;
        exp_q.push_back({cctl, 32'(r)});
        sent++;
        pend = 1'b0;
      end
      @(negedge clk);
    end
    s_tvalid[2] = 2'b00;
    check("u4_sent", 64'(sent), 64'(NB));
    check("u4_got", 64'(got), 64'(NB));
    check("u4_qempty", 64'(exp_q.size()), 64'd0);
    repeat (6) @(negedge clk);
    check("u4_no_dup", 64'(m_tvalid[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish in time");
  end

endmodule
